mdu: RTL

MDU -- requirements
Module: mdu

---
 rtl/mdu_pkg.sv | 40 ++++
 rtl/mdu_div.sv | 62 ++++++
 rtl/mdu.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared definitions for the multiply/divide unit. Holds the
//               op encodings, controller state encoding, default busy-cycle
//               counts and a small op-decode helper.
//               Ports: none (package).
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

  // Op encodings presented on the mdu op input
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  // Default busy-cycle counts
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  // Controller states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // MULT and DIV treat their operands as two's complement; the U forms do not
  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_mult(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_div.sv
`default_nettype none
// ============================================================================
// Module      : mdu_div
// Description : Combinational signed/unsigned divider producing quotient and
//               remainder with MIPS-style corner-case results.
//               Ports: dividend, divisor (WIDTH) and is_signed in;
//                      quotient, remainder (WIDTH) out.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_div #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam logic [WIDTH-1:0] C_MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] C_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH-1:0] w_safe_b;
  logic [WIDTH-1:0] w_uq;
  logic [WIDTH-1:0] w_ur;
  logic             w_div0;
  logic             w_ovf;

  assign w_neg_a = is_signed & dividend[WIDTH-1];
  assign w_neg_b = is_signed & divisor[WIDTH-1];
  assign w_mag_a = w_neg_a ? (~dividend + C_ONE) : dividend;
  assign w_mag_b = w_neg_b ? (~divisor + C_ONE) : divisor;
  assign w_div0  = (divisor == '0);
  assign w_ovf   = is_signed && (dividend == C_MIN_VAL) && (divisor == '1);

  // Keep the core divider away from a zero divisor; that case is overridden below
  assign w_safe_b = w_div0 ? C_ONE : w_mag_b;
  assign w_uq     = w_mag_a / w_safe_b;
  assign w_ur     = w_mag_a % w_safe_b;

  always_comb begin
    quotient  = w_uq;
    remainder = w_ur;
    if (w_div0) begin
      quotient  = '1;
      remainder = dividend;
    end else if (w_ovf) begin
      quotient  = C_MIN_VAL;
      remainder = '0;
    end else begin
      // Truncate toward zero; remainder follows the dividend's sign
      if (w_neg_a ^ w_neg_b) quotient  = ~w_uq + C_ONE;
      if (w_neg_a)           remainder = ~w_ur + C_ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module      : mdu
// Description : Multi-cycle multiply/divide unit with HI/LO registers.
//               Ports: clk, reset (async active-high), start, op[2:0],
//                      src_a, src_b, flush in; busy, done, hi, lo out.
//               Results are computed combinationally from latched operands
//               and committed after a fixed number of busy cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [7:0] C_MULT_CNT = 8'(MULT_CYCLES);
  localparam logic [7:0] C_DIV_CNT  = 8'(DIV_CYCLES);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q,   cnt_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic [WIDTH-1:0] hi_q,    hi_d;
  logic [WIDTH-1:0] lo_q,    lo_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [2:0]       op_q,    op_d;

  // Result datapath, driven from the latched operands
  logic                 w_signed;
  logic                 w_mult;
  logic [2*WIDTH-1:0]   w_mul_a;
  logic [2*WIDTH-1:0]   w_mul_b;
  logic [2*WIDTH-1:0]   w_product;
  logic [WIDTH-1:0]     w_quot;
  logic [WIDTH-1:0]     w_rem;
  logic [WIDTH-1:0]     w_res_hi;
  logic [WIDTH-1:0]     w_res_lo;

  assign w_signed = op_is_signed(op_q);
  assign w_mult   = op_is_mult(op_q);

  // Sign- or zero-extend to 2*WIDTH; the low 2*WIDTH bits of the product are
  // then correct for both signed and unsigned operands.
  assign w_mul_a   = {{WIDTH{w_signed & a_q[WIDTH-1]}}, a_q};
  assign w_mul_b   = {{WIDTH{w_signed & b_q[WIDTH-1]}}, b_q};
  assign w_product = w_mul_a * w_mul_b;

  mdu_div #(
    .WIDTH (WIDTH)
  ) u_div (
    .dividend  (a_q),
    .divisor   (b_q),
    .is_signed (w_signed),
    .quotient  (w_quot),
    .remainder (w_rem)
  );

  assign w_res_hi = w_mult ? w_product[2*WIDTH-1:WIDTH] : w_rem;
  assign w_res_lo = w_mult ? w_product[WIDTH-1:0]       : w_quot;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;

    unique case (state_q)
      ST_IDLE: begin
        // flush outranks a same-cycle issue
        if (start && !flush) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              a_d     = src_a;
              b_d     = src_b;
              op_d    = op;
              cnt_d   = op_is_mult(op) ? C_MULT_CNT : C_DIV_CNT;
              busy_d  = 1'b1;
              state_d = ST_RUN;
            end
            OP_MTHI: hi_d = src_a;
            OP_MTLO: lo_d = src_a;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == 8'd1) begin
          // Last busy cycle: commit at this edge, done shows next cycle
          hi_d    = w_res_hi;
          lo_d    = w_res_lo;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire
